// File: rtl/point_command_sequencer.sv
// Sequencer that issues one point-move command to the linear-point selection block,
// watches the addressed status field and reports OK / FAULT / TIMEOUT / BAD_LP.
module point_command_sequencer #(
  parameter int unsigned NUM_LP         = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_lp_i,
  input  logic [2:0]            req_object_i,
  input  logic                  req_command_i,
  output logic [2:0]            lp_o,
  output logic [2:0]            object_number_o,
  output logic                  command_o,
  output logic                  en_o,
  input  logic [5*NUM_LP-1:0]   status_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_code_o,
  output logic                  busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] CodeOk      = 2'b00;
  localparam logic [1:0] CodeFault   = 2'b01;
  localparam logic [1:0] CodeTimeout = 2'b10;
  localparam logic [1:0] CodeBadLp   = 2'b11;

  typedef enum logic [2:0] {StIdle, StIssue, StSettle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [2:0]    lp_q, lp_d;
  logic [2:0]    obj_q, obj_d;
  logic          cmd_q, cmd_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] settle_q, settle_d;

  logic          req_ready_q, req_ready_d;
  logic          en_q, en_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic [2:0]    lp_out_q, lp_out_d;
  logic [2:0]    obj_out_q, obj_out_d;
  logic          cmd_out_q, cmd_out_d;

  logic [4:0]    field;
  logic [TW-1:0] tmo_inc;
  logic          unused_field_bits;

  always_comb begin
    field = '0;
    for (int unsigned k = 0; k < NUM_LP; k++) begin
      if ({29'd0, lp_q} == k) field = status_i[5*k +: 5];
    end
  end

  assign unused_field_bits = ^field[2:1];

  // Counter holds the number of cycles elapsed since the enable pulse, saturating.
  assign tmo_inc = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    lp_d     = lp_q;
    obj_d    = obj_q;
    cmd_d    = cmd_q;
    code_d   = code_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          lp_d  = req_lp_i;
          obj_d = req_object_i;
          cmd_d = req_command_i;
          tmo_d = '0;
          if ({29'd0, req_lp_i} >= NUM_LP) begin
            code_d  = CodeBadLp;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        tmo_d    = TW'(1);
        settle_d = SW'(SETTLE_CYCLES);
        state_d  = StSettle;
      end
      StSettle: begin
        tmo_d    = tmo_inc;
        settle_d = settle_q - 1'b1;
        if (settle_q <= SW'(1)) state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_inc;
        if (field[3]) begin
          code_d  = CodeFault;
          state_d = StResp;
        end else if (!field[4] && (field[0] == cmd_q)) begin
          code_d  = CodeOk;
          state_d = StResp;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          code_d  = CodeTimeout;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output flops are loaded from the next state so every output is a plain register.
  always_comb begin
    req_ready_d  = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
    en_d         = (state_d == StIssue);
    resp_valid_d = (state_d == StResp);
    lp_out_d     = en_d ? lp_d  : lp_out_q;
    obj_out_d    = en_d ? obj_d : obj_out_q;
    cmd_out_d    = en_d ? cmd_d : cmd_out_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      lp_q         <= '0;
      obj_q        <= '0;
      cmd_q        <= 1'b0;
      code_q       <= CodeOk;
      tmo_q        <= '0;
      settle_q     <= '0;
      req_ready_q  <= 1'b1;
      en_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      lp_out_q     <= '0;
      obj_out_q    <= '0;
      cmd_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lp_q         <= lp_d;
      obj_q        <= obj_d;
      cmd_q        <= cmd_d;
      code_q       <= code_d;
      tmo_q        <= tmo_d;
      settle_q     <= settle_d;
      req_ready_q  <= req_ready_d;
      en_q         <= en_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      lp_out_q     <= lp_out_d;
      obj_out_q    <= obj_out_d;
      cmd_out_q    <= cmd_out_d;
    end
  end

  assign req_ready_o     = req_ready_q;
  assign en_o            = en_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_code_o     = code_q;
  assign busy_o          = busy_q;
  assign lp_o            = lp_out_q;
  assign object_number_o = obj_out_q;
  assign command_o       = cmd_out_q;

endmodule
